// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops DSIZE-bit entries from the async FIFO and assembles
// PACK of them into one wide word on a valid/ready output, with flush support.

module fifo_rd_packer_lane #(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             clr,
    input  logic             wr,
    input  logic [DSIZE-1:0] d,
    output logic [DSIZE-1:0] q
);
    // A write wins over a clear so a pop in the load cycle lands in lane 0.
    always_ff @(posedge rclk) begin
        if (rrst)     q <= '0;
        else if (wr)  q <= d;
        else if (clr) q <= '0;
    end
endmodule

module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic [DSIZE*PACK-1:0] out_data,
    output logic [3:0]            out_bcnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            acc_cnt
);
    typedef enum logic {ACC, FLUSH} state_t;

    state_t                          state, state_nxt;
    logic                            flush_pend;
    logic                            out_free;
    logic                            load;
    logic                            acc_full;
    logic [PACK-1:0][DSIZE-1:0]      acc_data;
    logic [PACK-1:0][DSIZE-1:0]      acc_masked;
    logic [PACK-1:0]                 lane_wr;

    assign flush_pend = (state == FLUSH);
    assign acc_full   = (acc_cnt == 4'(PACK));
    assign out_free   = !out_valid || out_ready;
    assign load       = out_free && (acc_full || (flush_pend && acc_cnt != 4'd0));
    assign rinc       = !rrst && !rempty && !flush_pend && (!acc_full || load);

    genvar i;
    generate
        for (i = 0; i < PACK; i++) begin : g_lane
            // On a load the popped entry restarts the word in lane 0.
            assign lane_wr[i]    = rinc && (load ? (i == 0) : (acc_cnt == 4'(i)));
            assign acc_masked[i] = (acc_cnt > 4'(i)) ? acc_data[i] : '0;

            fifo_rd_packer_lane #(.DSIZE(DSIZE)) u_lane (
                .rclk (rclk),
                .rrst (rrst),
                .clr  (load),
                .wr   (lane_wr[i]),
                .d    (rdata),
                .q    (acc_data[i])
            );
        end
    endgenerate

    always_ff @(posedge rclk) begin
        if (rrst) begin
            acc_cnt <= 4'd0;
        end else if (load) begin
            acc_cnt <= rinc ? 4'd1 : 4'd0;
        end else if (rinc) begin
            acc_cnt <= acc_cnt + 4'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bcnt  <= 4'd0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= acc_masked;
            out_bcnt  <= acc_cnt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) state <= ACC;
        else      state <= state_nxt;
    end

    // Leaving FLUSH needs either nothing to send or the partial word taken.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (flush) state_nxt = FLUSH;
            FLUSH:   if (acc_cnt == 4'd0 || load) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO stand-in, queue-level reference
// model checked every cycle, directed scenarios plus a randomized stream.
module tb_fifo_rd_packer;
    localparam int DSIZE = 8;
    localparam int PACK  = 4;
    localparam int W     = DSIZE * PACK;

    logic             rclk = 1'b0;
    logic             rrst = 1'b1;
    logic             rempty = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             rinc;
    logic [W-1:0]     out_data;
    logic [3:0]       out_bcnt;
    logic             out_valid;
    logic [3:0]       acc_cnt;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_bcnt  (out_bcnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]   fifo_q[$];
    logic [7:0]   acc_q[$];
    logic [7:0]   pushed_q[$];
    logic [W+3:0] got_q[$];
    bit           m_ov = 0;
    bit           m_fp = 0;
    logic [W-1:0] m_data = '0;
    int           m_bcnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_acc();
        logic [W-1:0] r = '0;
        for (int k = 0; k < acc_q.size(); k++) r[k*DSIZE +: DSIZE] = acc_q[k];
        return r;
    endfunction

    // One clock: present FIFO head, check DUT vs model, advance both.
    task automatic tick();
        int         n;
        bit         m_load, m_pop, fp_n, r_s;
        logic [7:0] byte_s;
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
        #1;
        n      = acc_q.size();
        m_load = !rrst && (!m_ov || out_ready) && (n == PACK || (m_fp && n != 0));
        m_pop  = !rrst && !rempty && !m_fp && (n < PACK || m_load);
        chk("rinc", rinc, m_pop);
        chk("rinc_while_empty", rinc & rempty, 0);
        chk("out_valid", out_valid, m_ov);
        chk("acc_cnt", acc_cnt, n);
        if (m_ov) begin
            chk("out_data", out_data, m_data);
            chk("out_bcnt", out_bcnt, m_bcnt);
        end
        if (out_valid && out_ready) got_q.push_back({out_bcnt, out_data});
        r_s    = rinc;
        byte_s = rdata;
        @(posedge rclk);
        if (r_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (rrst) begin
            acc_q.delete();
            m_ov = 0; m_fp = 0; m_data = '0; m_bcnt = 0;
        end else begin
            fp_n = m_fp ? !(n == 0 || m_load) : flush;
            if (m_load) begin
                m_data = pack_acc();
                m_bcnt = n;
                m_ov   = 1;
                acc_q.delete();
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (m_pop) acc_q.push_back(byte_s);
            m_fp = fp_n;
        end
        #1;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) tick();
        chk("wait_words", got_q.size() >= n, 1);
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [3:0] bc, input logic [W-1:0] d);
        if (idx < got_q.size()) chk(tag, got_q[idx], {bc, d});
        else chk(tag, 0, {bc, d});
    endtask

    initial begin
        logic [7:0] got_b[$];
        logic [W+3:0] wd;
        int bc;

        // reset
        out_ready = 1'b1;
        @(posedge rclk); #1;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_acc_cnt", acc_cnt, 0);
        chk("rst_data", out_data, 0);
        chk("rst_bcnt", out_bcnt, 0);
        rrst = 1'b0;

        // 1: two full words back to back
        got_q.delete();
        for (int k = 0; k < 8; k++) fifo_q.push_back(8'(k));
        wait_words(2, 40);
        chk_word("t1_w0", 0, 4, 32'h03020100);
        chk_word("t1_w1", 1, 4, 32'h07060504);
        repeat (3) tick();

        // 2: backpressure
        got_q.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) fifo_q.push_back(8'(8'h10 + k));
        repeat (20) tick();
        chk("t2_hold_data", out_data, 32'h13121110);
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_acc_full", acc_cnt, 4);
        chk("t2_fifo_left", fifo_q.size(), 4);
        chk("t2_rinc_low", rinc, 0);
        out_ready = 1'b1;
        wait_words(3, 40);
        chk_word("t2_w0", 0, 4, 32'h13121110);
        chk_word("t2_w1", 1, 4, 32'h17161514);
        chk_word("t2_w2", 2, 4, 32'h1B1A1918);
        repeat (3) tick();

        // 3: flush a 3-byte partial
        got_q.delete();
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2); fifo_q.push_back(8'hA3);
        for (int k = 0; k < 20 && acc_cnt != 4'd3; k++) tick();
        chk("t3_acc3", acc_cnt, 3);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_words(1, 20);
        chk_word("t3_partial", 0, 3, 32'h00A3A2A1);
        repeat (2) tick();
        chk("t3_acc_after", acc_cnt, 0);

        // 4: flush with nothing held
        got_q.delete();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (4) tick();
        chk("t4_no_word", got_q.size(), 0);
        chk("t4_valid_low", out_valid, 0);
        for (int k = 0; k < 4; k++) fifo_q.push_back(8'(8'h30 + k));
        wait_words(1, 20);
        chk_word("t4_word", 0, 4, 32'h33323130);
        repeat (3) tick();

        // 5: reset mid-operation
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) fifo_q.push_back(8'(8'h40 + k));
        repeat (15) tick();
        chk("t5_acc2", acc_cnt, 2);
        chk("t5_pending", out_valid, 1);
        rrst = 1'b1; tick(); rrst = 1'b0;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_acc", acc_cnt, 0);
        chk("t5_rst_data", out_data, 0);
        got_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) fifo_q.push_back(8'(8'h55 + k));
        wait_words(1, 20);
        chk_word("t5_word", 0, 4, 32'h58575655);
        repeat (3) tick();

        // 6: flush after two pops of six
        got_q.delete();
        for (int k = 0; k < 6; k++) fifo_q.push_back(8'(8'h20 + k));
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t6_acc2", acc_cnt, 2);
        chk("t6_pause", rinc, 0);
        chk("t6_fifo_left", fifo_q.size(), 4);
        wait_words(2, 40);
        chk_word("t6_w0", 0, 2, 32'h00002120);
        chk_word("t6_w1", 1, 4, 32'h25242322);
        repeat (3) tick();

        // random stream: order and completeness through the packer
        got_q.delete();
        pushed_q.delete();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) begin
                logic [7:0] b;
                b = 8'($urandom);
                fifo_q.push_back(b);
                pushed_q.push_back(b);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            flush = 1'b1; tick(); flush = 1'b0;
            repeat (20) tick();
        end
        for (int i = 0; i < got_q.size(); i++) begin
            wd = got_q[i];
            bc = int'(wd[W+3:W]);
            for (int b = 0; b < bc; b++) got_b.push_back(wd[b*DSIZE +: DSIZE]);
        end
        chk("rand_len", got_b.size(), pushed_q.size());
        for (int i = 0; i < pushed_q.size() && i < got_b.size(); i++)
            chk("rand_byte", got_b[i], pushed_q[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
